// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file, one write port, two registered read ports
// Optional same-edge write forwarding and optional hardwired-zero entry 0.
module reg_file_param #(
    parameter int DW      = 16,
    parameter int AW      = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          en_in,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs,
    output logic          en_out,
    output logic [DW-1:0] rd_q,
    output logic [DW-1:0] rs_q
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_d;
    logic [DW-1:0] rs_d;
    logic          wr_ok;

    // A write to the hardwired-zero entry is dropped, so it never needs masking on store.
    assign wr_ok = we && !((ZERO_R0 != 0) && (waddr == '0));

    always_comb begin
        rd_d = mem_q[rd];
        if ((BYPASS != 0) && we && (waddr == rd)) begin
            rd_d = wdata;
        end
        if ((ZERO_R0 != 0) && (rd == '0)) begin
            rd_d = '0;
        end
    end

    always_comb begin
        rs_d = mem_q[rs];
        if ((BYPASS != 0) && we && (waddr == rs)) begin
            rs_d = wdata;
        end
        if ((ZERO_R0 != 0) && (rs == '0)) begin
            rs_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data holds its last value while no request is made.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out <= 1'b0;
            rd_q   <= '0;
            rs_q   <= '0;
        end else begin
            en_out <= en_in;
            if (en_in) begin
                rd_q <= rd_d;
                rs_q <= rs_d;
            end
        end
    end

endmodule
